// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/decode front end: instruction width,
// instruction field positions and the fetch FSM state encoding.
package cpu_pkg;

    localparam int INST_W   = 8;

    localparam int OP_MSB   = 7;
    localparam int OP_LSB   = 6;
    localparam int SRC1_MSB = 5;
    localparam int SRC1_LSB = 4;
    localparam int SRC2_MSB = 3;
    localparam int SRC2_LSB = 2;
    localparam int DEST_MSB = 1;
    localparam int DEST_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_store.sv
// Instruction store: DEPTH x INST_W array, synchronous write, asynchronous read.
// Contents are deliberately not reset so a program survives a pipeline reset.
module inst_store #(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 4,
    parameter int INST_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PC_W-1:0]   waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic [PC_W-1:0]   raddr,
    output logic [INST_W-1:0] rdata
);

    logic [INST_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: pc, fetch FSM and single-stage output register.
// Build option INST_FETCH_WRAP_EN: wrap to address 0 at PROG_LEN instead of halting.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int PC_W     = 4,
    parameter int INST_W   = cpu_pkg::INST_W,
    parameter int PROG_LEN = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_en,
    input  logic [PC_W-1:0]   load_addr,
    input  logic [INST_W-1:0] load_data,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              inst_ready,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic              busy,
    output logic              done
);

    // pc carries one extra bit so that it can hold PROG_LEN == DEPTH.
    localparam logic [PC_W:0] LEN = (PC_W + 1)'(PROG_LEN);

    fetch_state_t      state, state_n;
    logic [PC_W:0]     pc, pc_n;
    logic              flush, flush_n;
    logic              valid_n;
    logic [INST_W-1:0] inst_n;
    logic [PC_W-1:0]   inst_pc_n;
    logic              we;
    logic [PC_W-1:0]   rd_addr;
    logic [INST_W-1:0] rd_data;
    logic              slot_free;
    logic [PC_W:0]     rpc_ext;

    // Handshake: inst/inst_pc transfer on a rising edge where inst_valid and
    // inst_ready are both high and no redirect is requested; while inst_valid
    // is high and inst_ready low, inst and inst_pc hold stable.
    assign slot_free = !inst_valid || inst_ready;
    assign rpc_ext   = {1'b0, redirect_pc};
    assign rd_addr   = (state == FETCH && pc < LEN) ? pc[PC_W-1:0] : '0;

    inst_store #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W),
        .INST_W(INST_W)
    ) u_store (
        .clk  (clk),
        .we   (we),
        .waddr(load_addr),
        .wdata(load_data),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        flush_n   = 1'b0;
        valid_n   = inst_valid;
        inst_n    = inst;
        inst_pc_n = inst_pc;
        we        = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_n   = FETCH;
                    inst_n    = rd_data;
                    inst_pc_n = '0;
                    valid_n   = 1'b1;
                    pc_n      = (PC_W + 1)'(1);
                end else begin
                    we = load_en;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    valid_n = 1'b0;
                    if (rpc_ext >= LEN) begin
`ifdef INST_FETCH_WRAP_EN
                        pc_n    = rpc_ext % LEN;
                        flush_n = 1'b1;
`else
                        pc_n    = rpc_ext;
                        state_n = HALT;
`endif
                    end else begin
                        pc_n    = rpc_ext;
                        flush_n = 1'b1;
                    end
                end else if (slot_free && !flush) begin
                    if (pc < LEN) begin
                        inst_n    = rd_data;
                        inst_pc_n = pc[PC_W-1:0];
                        valid_n   = 1'b1;
                        pc_n      = pc + 1'b1;
                    end else begin
`ifdef INST_FETCH_WRAP_EN
                        // rd_addr already points at address 0 here.
                        inst_n    = rd_data;
                        inst_pc_n = '0;
                        valid_n   = 1'b1;
                        pc_n      = (PC_W + 1)'(1);
`else
                        valid_n = 1'b0;
                        state_n = HALT;
`endif
                    end
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= '0;
            flush      <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            flush      <= flush_n;
            inst_valid <= valid_n;
            inst       <= inst_n;
            inst_pc    <= inst_pc_n;
            busy       <= (state_n == FETCH);
            done       <= (state_n == HALT);
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch with a 4-instruction program; the wrap-mode table is
// selected when INST_FETCH_WRAP_EN is defined.
module tb_inst_fetch;

    localparam int PC_W   = 4;
    localparam int INST_W = 8;

    typedef struct {
        logic             start;
        logic             ready;
        logic             redir;
        logic [PC_W-1:0]  rpc;
        logic             v;
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]  pc;
        logic             busy;
        logic             done;
    } vec_t;

    logic              clk;
    logic              reset;
    logic              start;
    logic              load_en;
    logic [PC_W-1:0]   load_addr;
    logic [INST_W-1:0] load_data;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              inst_ready;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;
    logic              busy;
    logic              done;

    int passed = 0;
    int total  = 0;
    logic sb_en = 1'b0;
    logic [PC_W+INST_W-1:0] exp_q[$];
    vec_t vecs[$];
    logic [INST_W-1:0] prog [4];

    inst_fetch #(
        .DEPTH   (16),
        .PC_W    (PC_W),
        .INST_W  (INST_W),
        .PROG_LEN(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_ready    (inst_ready),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic st, input logic rdy, input logic rd, input logic [PC_W-1:0] rp,
                       input logic v, input logic [INST_W-1:0] in, input logic [PC_W-1:0] p,
                       input logic b, input logic d);
        vec_t r;
        r.start = st; r.ready = rdy; r.redir = rd; r.rpc = rp;
        r.v = v; r.inst = in; r.pc = p; r.busy = b; r.done = d;
        vecs.push_back(r);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Scoreboard: every accepted transfer must match the head of exp_q.
    always @(negedge clk) begin
        if (sb_en && !reset && inst_valid && inst_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_accept", {20'd0, inst_pc, inst}, 32'hFFFF_FFFF);
            end else begin
                chk("sb_accept", {20'd0, inst_pc, inst}, {20'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        prog[0] = 8'h1B; prog[1] = 8'h64; prog[2] = 8'hA5; prog[3] = 8'hFF;
        reset = 1'b1; start = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        #2;
        chk("reset_outputs", {inst_valid, inst, inst_pc, busy, done}, '0);
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            load_en = 1'b1; load_addr = PC_W'(i); load_data = prog[i];
            tick();
        end
        load_en = 1'b0;

`ifdef INST_FETCH_WRAP_EN
        add(1, 1, 0, 0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 0, 0, 1, 8'h1B, 0, 1, 0);
        add(0, 1, 0, 0, 1, 8'h64, 1, 1, 0);
        add(0, 1, 0, 0, 1, 8'hA5, 2, 1, 0);
        add(0, 1, 0, 0, 1, 8'hFF, 3, 1, 0);
        add(0, 1, 0, 0, 1, 8'h1B, 0, 1, 0);
        add(0, 1, 1, 7, 1, 8'h64, 1, 1, 0);
        add(0, 1, 0, 0, 0, 8'h00, 0, 1, 0);
        add(0, 1, 0, 0, 0, 8'h00, 0, 1, 0);
        add(0, 1, 0, 0, 1, 8'hFF, 3, 1, 0);
        add(0, 1, 0, 0, 1, 8'h1B, 0, 1, 0);
        add(0, 0, 0, 0, 1, 8'h64, 1, 1, 0);
`else
        // straight run to halt
        add(1, 1, 0, 0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 0, 0, 1, 8'h1B, 0, 1, 0);
        add(0, 1, 0, 0, 1, 8'h64, 1, 1, 0);
        add(0, 1, 0, 0, 1, 8'hA5, 2, 1, 0);
        add(0, 1, 0, 0, 1, 8'hFF, 3, 1, 0);
        add(0, 1, 0, 0, 0, 8'h00, 0, 0, 1);
        add(0, 1, 0, 0, 0, 8'h00, 0, 0, 1);
        // back-pressure on the first instruction
        add(1, 0, 0, 0, 0, 8'h00, 0, 0, 1);
        add(0, 0, 0, 0, 1, 8'h1B, 0, 1, 0);
        add(0, 0, 0, 0, 1, 8'h1B, 0, 1, 0);
        add(0, 0, 0, 0, 1, 8'h1B, 0, 1, 0);
        add(0, 1, 0, 0, 1, 8'h1B, 0, 1, 0);
        add(0, 1, 0, 0, 1, 8'h64, 1, 1, 0);
        add(0, 1, 0, 0, 1, 8'hA5, 2, 1, 0);
        add(0, 1, 0, 0, 1, 8'hFF, 3, 1, 0);
        add(0, 1, 0, 0, 0, 8'h00, 0, 0, 1);
        // in-range redirect: two bubble cycles
        add(1, 1, 0, 0, 0, 8'h00, 0, 0, 1);
        add(0, 1, 0, 0, 1, 8'h1B, 0, 1, 0);
        add(0, 1, 1, 2, 1, 8'h64, 1, 1, 0);
        add(0, 1, 0, 0, 0, 8'h00, 0, 1, 0);
        add(0, 1, 0, 0, 0, 8'h00, 0, 1, 0);
        add(0, 1, 0, 0, 1, 8'hA5, 2, 1, 0);
        add(0, 1, 0, 0, 1, 8'hFF, 3, 1, 0);
        add(0, 1, 0, 0, 0, 8'h00, 0, 0, 1);
        // out-of-range redirect halts, restart from 0
        add(1, 1, 0, 0, 0, 8'h00, 0, 0, 1);
        add(0, 1, 1, 7, 1, 8'h1B, 0, 1, 0);
        add(0, 1, 0, 0, 0, 8'h00, 0, 0, 1);
        add(1, 1, 0, 0, 0, 8'h00, 0, 0, 1);
        add(0, 1, 0, 0, 1, 8'h1B, 0, 1, 0);
        add(0, 0, 0, 0, 1, 8'h64, 1, 1, 0);
`endif

        sb_en = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start;
            inst_ready = vecs[i].ready;
            redirect_valid = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            if (vecs[i].v && vecs[i].ready && !vecs[i].redir)
                exp_q.push_back({vecs[i].pc, vecs[i].inst});
            @(negedge clk);
            if (vecs[i].v)
                chk($sformatf("row%0d", i), {inst_valid, busy, done, inst, inst_pc},
                    {vecs[i].v, vecs[i].busy, vecs[i].done, vecs[i].inst, vecs[i].pc});
            else
                chk($sformatf("row%0d", i), {inst_valid, busy, done},
                    {vecs[i].v, vecs[i].busy, vecs[i].done});
            tick();
        end
        start = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
        sb_en = 1'b0;
        chk("sb_drained", exp_q.size(), 0);

        // asynchronous reset between edges while an instruction is presented
        pulse_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_clear", {inst_valid, inst, inst_pc, busy, done}, '0);
        tick();
        reset = 1'b0;

        // store retained across reset
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_after_reset", {inst_valid, busy, inst, inst_pc}, {1'b1, 1'b1, 8'h1B, 4'h0});

        // load attempts during FETCH must be ignored
        inst_ready = 1'b1;
        load_en = 1'b1; load_addr = '0; load_data = 8'h00;
        tick(); tick(); tick();
        load_en = 1'b0; inst_ready = 1'b0;
        pulse_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_in_fetch_ignored", {inst_valid, inst, inst_pc}, {1'b1, 8'h1B, 4'h0});

        // load in the same cycle as start must be ignored
        pulse_reset();
        start = 1'b1; load_en = 1'b1; load_addr = '0; load_data = 8'hEE;
        tick();
        start = 1'b0; load_en = 1'b0;
        chk("start_load_first", {inst_valid, inst}, {1'b1, 8'h1B});
        pulse_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_load_ignored", {inst_valid, inst, inst_pc}, {1'b1, 8'h1B, 4'h0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
